ifetch_unit: RTL and testbench

Instruction fetch front end: the requester side of the instruction memory read port.
- Owns the byte program counter and drives the word index to the instruction memory.
- Tracks the memory's fixed 1-cycle synchronous read latency.
- Presents {instruction, pc} to decode with a valid/ready handshake.
- Handles decode back-pressure, branch/jump redirect with kill of the in-flight fetch, and fetch enable/halt.

---
 rtl/ifetch_unit.sv | 129 ++++++++++++
 tb/tb_ifetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifetch_unit: instruction fetch front end with PC, 1-cycle imem, valid/ready |
// | Optional macro IFU_PERF_CNT_EN adds fetched/stall/kill counters. Rev 1.0   |
// +----------------------------------------------------------------------------+
module ifetch_unit #(
  parameter int          IDX_W    = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_en,
  output logic [IDX_W-1:0] pc_out,
  input  logic [31:0]      insn_in,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             insn_valid,
  output logic [31:0]      insn,
  output logic [31:0]      insn_pc,
  input  logic             insn_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_kill
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic             resp_vld_q, resp_vld_d;
  logic             w_adv;
  logic [31:0]      w_redir_pc;
  logic [IDX_W-1:0] w_fetch_idx;
  logic             w_unused_lsbs;

  assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
  assign w_unused_lsbs = ^redirect_pc[1:0];
  assign w_adv         = ~resp_vld_q | insn_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    resp_pc_d   = resp_pc_q;
    resp_vld_d  = resp_vld_q;
    w_fetch_idx = pc_q[IDX_W+1:2];
    case (state_q)
      S_IDLE: begin
        resp_vld_d = 1'b0;
        if (redirect_valid) pc_d = w_redir_pc;
        if (fetch_en) state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          w_fetch_idx = redirect_pc[IDX_W+1:2];
          resp_vld_d  = 1'b1;
          resp_pc_d   = w_redir_pc;
          pc_d        = w_redir_pc + 32'd4;
        end else if (~fetch_en & w_adv) begin
          resp_vld_d = 1'b0;
          state_d    = S_IDLE;
        end else if (w_adv) begin
          resp_vld_d = 1'b1;
          resp_pc_d  = pc_q;
          pc_d       = pc_q + 32'd4;
        end else begin
          // Stall: re-read the held word so insn_in stays equal to insn next cycle.
          w_fetch_idx = resp_pc_q[IDX_W+1:2];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      resp_pc_q  <= 32'd0;
      resp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      resp_vld_q <= resp_vld_d;
    end
  end

  assign pc_out     = w_fetch_idx;
  assign insn_valid = resp_vld_q & ~redirect_valid;
  assign insn       = insn_in;
  assign insn_pc    = resp_pc_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_kill_q, perf_kill_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, insn_valid & insn_ready};
    perf_stall_d   = perf_stall_q + {31'd0, insn_valid & ~insn_ready};
    perf_kill_d    = perf_kill_q + {31'd0, resp_vld_q & redirect_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
      perf_kill_q    <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
      perf_kill_q    <= perf_kill_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_kill    = perf_kill_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifetch_unit: directed + random bench for ifetch_unit, transaction model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_ifetch_unit;
  localparam int          IDX_W    = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fetch_en;
  logic [IDX_W-1:0] pc_out;
  logic [31:0]      insn_in;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             insn_valid;
  logic [31:0]      insn;
  logic [31:0]      insn_pc;
  logic             insn_ready;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]      perf_fetched, perf_stall, perf_kill;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:(1<<IDX_W)-1];

  // Expected-stream model: next pc decode must accept, plus one cycle of history.
  logic [31:0] exp_pc;
  bit          prev_stall, prev_en, prev_redir, hist_ok;
  logic [31:0] prev_pc, prev_insn;
  int          en_run;
  int          n_fetched, n_stall;

  ifetch_unit #(.IDX_W(IDX_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .pc_out         (pc_out),
    .insn_in        (insn_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .insn_ready     (insn_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_kill      (perf_kill)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory with one-cycle synchronous read.
  always @(posedge clk) insn_in <= mem[pc_out];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc     = RESET_PC;
    prev_stall = 1'b0;
    prev_en    = 1'b0;
    prev_redir = 1'b0;
    hist_ok    = 1'b0;
    prev_pc    = 32'd0;
    prev_insn  = 32'd0;
    en_run     = 0;
    n_fetched  = 0;
    n_stall    = 0;
  endtask

  task automatic observe();
    if (hist_ok && prev_stall && !redirect_valid) begin
      check("hold_valid", {31'd0, insn_valid}, 32'd1);
      check("hold_pc", insn_pc, prev_pc);
      check("hold_insn", insn, prev_insn);
    end
    if (redirect_valid)
      check("kill_valid", {31'd0, insn_valid}, 32'd0);
    else if (en_run >= 2)
      check("live_valid", {31'd0, insn_valid}, 32'd1);
    else if (hist_ok && !prev_en && !prev_stall && !prev_redir)
      check("idle_valid", {31'd0, insn_valid}, 32'd0);

    if (insn_valid && insn_ready) begin
      check("acc_pc", insn_pc, exp_pc);
      check("acc_insn", insn, mem[exp_pc[IDX_W+1:2]]);
      exp_pc = exp_pc + 32'd4;
      n_fetched++;
    end
    if (insn_valid && !insn_ready) n_stall++;
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};

    prev_stall = insn_valid && !insn_ready;
    prev_pc    = insn_pc;
    prev_insn  = insn;
    prev_en    = fetch_en;
    prev_redir = redirect_valid;
    en_run     = fetch_en ? en_run + 1 : 0;
    hist_ok    = 1'b1;
  endtask

  // Apply inputs for one cycle, then sample just before the closing edge.
  task automatic drv(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    fetch_en       = fe;
    insn_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #4;
    observe();
  endtask

  task automatic exp_out(input string tag, input bit v, input logic [31:0] pc,
                         input logic [31:0] ins, input int po);
    check({tag, "_valid"}, {31'd0, insn_valid}, {31'd0, v});
    if (v) begin
      check({tag, "_pc"}, insn_pc, pc);
      check({tag, "_insn"}, insn, ins);
    end
    if (po >= 0) check({tag, "_pcout"}, {22'd0, pc_out}, po);
  endtask

  initial begin
    for (int i = 0; i < (1 << IDX_W); i++) mem[i] = i;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    insn_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {31'd0, insn_valid}, 32'd0);
    check("rst_pc", insn_pc, 32'd0);
    check("rst_pcout", {22'd0, pc_out}, {22'd0, RESET_PC[IDX_W+1:2]});
    rst_n = 1'b1;

    // Start-up and back-to-back stream
    drv(0, 1, 0, 0);        exp_out("idle", 0, 0, 0, 0);
    drv(1, 1, 0, 0);        exp_out("en0", 0, 0, 0, 0);
    drv(1, 1, 0, 0);        exp_out("en1", 0, 0, 0, 0);
    drv(1, 1, 0, 0);        exp_out("first", 1, 32'h0, 0, 1);
    drv(1, 1, 0, 0);        exp_out("second", 1, 32'h4, 1, 2);
    // Three-cycle decode stall on 0x8
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0);      exp_out("stall", 1, 32'h8, 2, 2);
    end
    drv(1, 1, 0, 0);        exp_out("release", 1, 32'h8, 2, 3);
    drv(1, 1, 0, 0);        exp_out("after", 1, 32'hC, 3, 4);
    // Redirect kills the in-flight response for 0x10
    drv(1, 1, 1, 32'h103);  exp_out("redir", 0, 0, 0, 32'h40);
    drv(1, 1, 0, 0);        exp_out("tgt0", 1, 32'h100, 32'h40, 32'h41);
    drv(1, 1, 0, 0);        exp_out("tgt1", 1, 32'h104, 32'h41, 32'h42);
    // Redirect during a stall, into the wrap region
    drv(1, 0, 0, 0);        exp_out("pre_rs", 1, 32'h108, 32'h42, 32'h42);
    drv(1, 0, 1, 32'hFF8);  exp_out("redir_st", 0, 0, 0, 1022);
    drv(1, 1, 0, 0);        exp_out("wrap0", 1, 32'hFF8, 1022, 1023);
    drv(1, 1, 0, 0);        exp_out("wrap1", 1, 32'hFFC, 1023, 0);
    // fetch_en falls during a stall: held insn delivered once, then idle
    drv(0, 0, 0, 0);        exp_out("drain_st", 1, 32'h1000, 0, 0);
    drv(0, 1, 0, 0);        exp_out("drain_acc", 1, 32'h1000, 0, -1);
    drv(0, 1, 0, 0);        exp_out("drained", 0, 0, 0, 1);
    drv(1, 1, 0, 0);        exp_out("re_en0", 0, 0, 0, 1);
    drv(1, 1, 0, 0);        exp_out("re_en1", 0, 0, 0, 1);
    drv(1, 1, 0, 0);        exp_out("resume", 1, 32'h1004, 1, 2);

    // Asynchronous reset in the middle of a live stream
    @(negedge clk);
    #2;
`ifdef IFU_PERF_CNT_EN
    check("perf_fetched", perf_fetched, n_fetched);
    check("perf_stall", perf_stall, n_stall);
    check("perf_kill", perf_kill, 32'd2);
`endif
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    insn_ready     = 1'b0;
    #1;
    check("arst_valid", {31'd0, insn_valid}, 32'd0);
    check("arst_pcout", {22'd0, pc_out}, {22'd0, RESET_PC[IDX_W+1:2]});
    check("arst_pc", insn_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("arst_perf_f", perf_fetched, 32'd0);
    check("arst_perf_s", perf_stall, 32'd0);
    check("arst_perf_k", perf_kill, 32'd0);
`endif
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    drv(1, 1, 0, 0);        exp_out("post_rst0", 0, 0, 0, 0);
    drv(1, 1, 0, 0);        exp_out("post_rst1", 0, 0, 0, 0);
    drv(1, 1, 0, 0);        exp_out("post_rst2", 1, 32'h0, 0, 1);

    // Randomized traffic checked only against the expected-stream model
    for (int n = 0; n < 1500; n++) begin
      drv($urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 65,
          $urandom_range(0, 99) < 6,
          $urandom);
    end

    @(negedge clk);
    #1;
`ifdef IFU_PERF_CNT_EN
    check("end_perf_f", perf_fetched, n_fetched);
    check("end_perf_s", perf_stall, n_stall);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
